i_mem_pipe: RTL and testbench

Parametrised instruction memory with a valid/ready fetch port, configurable read latency, byte-enabled write port and fault reporting. Successor to the fixed 32x16 single-latency instruction RAM.
Sits between the fetch stage and the word-addressed storage array. Absorbs fetch-side stalls without losing in-flight reads. The write port is used by the program loader.

---
 rtl/i_mem_pkg.sv | 27 ++
 rtl/i_mem_resp_fifo.sv | 57 +++++
 rtl/i_mem_pipe.sv | 147 ++++++++++++++
 tb/tb_i_mem_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_mem_pkg.sv
// i_mem_pkg: shared constants, response record layout and helpers for the
// pipelined instruction memory.
package i_mem_pkg;

    // Deepest read latency the pipe is built for.
    localparam int RD_LAT_MAX = 4;

    // Fill bit for the data field of a faulting response (data reads as 0).
    localparam logic FAULT_FILL = 1'b0;

    // Response record layout {fault, data} at the default 32-bit word width.
    // The pipe declares the same layout locally at its own DATA_W.
    typedef struct packed {
        logic        fault;
        logic [31:0] data;
    } resp_rec_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/i_mem_resp_fifo.sv
// i_mem_resp_fifo: small response buffer. Any DEPTH >= 2 (not only powers of
// two). Storage is not reset; callers gate the head with 'empty'.
module i_mem_resp_fifo
    import i_mem_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointers and occupancy; clear discards everything, push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/i_mem_pipe.sv
// i_mem_pipe: instruction memory with a valid/ready fetch port, RD_LAT-cycle
// read pipeline, credit-guarded response buffer, byte-enabled loader write
// port and misaligned/out-of-range fault reporting.
module i_mem_pipe
    import i_mem_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_fault,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_din,
    input  logic                  flush
);

    localparam int          BYTES      = DATA_W / 8;
    localparam int          OFF_W      = clog2(BYTES);
    localparam int          IDX_W      = clog2(DEPTH);
    localparam int          BUF_D      = RD_LAT + 1;
    localparam int          CNT_W      = clog2(RD_LAT + 2);
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [32:0] SPAN       = 33'(DEPTH * BYTES);

    typedef struct packed {
        logic              fault;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rdy_en;
    logic [CNT_W-1:0]  infl_cnt;
    logic [CNT_W-1:0]  buf_cnt;
    logic              acc, exit_vld, push, pop;
    logic              buf_empty, buf_full;
    resp_t             acc_rec, exit_rec, head_rec;

    // A 33-bit offset puts any address below BASE_ADDR at or above 2^32, so
    // one range compare covers both the low and the high bound.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return ((a & ALIGN_MASK) != '0) || (off >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    // Credits: every accepted request owns a buffer slot until it is popped.
    assign req_ready = rdy_en && !flush &&
                       (({1'b0, infl_cnt} + {1'b0, buf_cnt}) < (CNT_W + 1)'(BUF_D));
    assign acc       = req_valid && req_ready;

    // Read-first: the array is sampled before this edge's write lands.
    always_comb begin
        acc_rec.fault = addr_bad(req_addr);
        acc_rec.data  = acc_rec.fault ? {DATA_W{FAULT_FILL}} : mem[word_idx(req_addr)];
    end

    // Byte-lane writes from the loader; bad addresses are dropped silently.
    always_ff @(posedge clk) begin
        if (wr_en && !addr_bad(wr_addr))
            for (int b = 0; b < BYTES; b++)
                if (wr_be[b]) mem[word_idx(wr_addr)][b*8 +: 8] <= wr_din[b*8 +: 8];
    end

    // Latency pipeline: RD_LAT-1 register stages, the buffer write is the last.
    generate
        if (RD_LAT == 1) begin : g_nopipe
            assign exit_vld = acc;
            assign exit_rec = acc_rec;
        end else begin : g_pipe
            localparam int STG = RD_LAT - 1;
            logic  [STG-1:0] vld_pipe;
            resp_t           rec_pipe [STG];

            // Shift valid/record down the stages; flush kills everything in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    for (int k = 0; k < STG; k++) rec_pipe[k] <= '0;
                end else begin
                    vld_pipe[0] <= acc && !flush;
                    rec_pipe[0] <= acc_rec;
                    for (int k = 1; k < STG; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1] && !flush;
                        rec_pipe[k] <= rec_pipe[k-1];
                    end
                end
            end

            assign exit_vld = vld_pipe[STG-1];
            assign exit_rec = rec_pipe[STG-1];
        end
    endgenerate

    assign push = exit_vld && !flush && !buf_full;
    assign pop  = !buf_empty && resp_ready && !flush;

    // Ready enable comes up on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    // In-flight count: accept adds, pipeline exit removes, in one expression.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        infl_cnt <= '0;
        else if (flush) infl_cnt <= '0;
        else            infl_cnt <= infl_cnt + CNT_W'(acc) - CNT_W'(exit_vld);
    end

    i_mem_resp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_D)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .din   (exit_rec),
        .pop   (pop),
        .dout  (head_rec),
        .count (buf_cnt),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign resp_valid = !buf_empty;
    assign resp_fault = !buf_empty && head_rec.fault;
    assign resp_data  = buf_empty ? '0 : head_rec.data;

endmodule

// File: tb/tb_i_mem_pipe.sv
// tb_i_mem_pipe: table-driven directed cases, flush/reset sequences and a
// randomized run, all scored against a queue-based reference model.
module tb_i_mem_pipe;

    localparam int          DW   = 32;
    localparam int          DP   = 16;
    localparam int          RL   = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid, req_ready, resp_valid, resp_ready, resp_fault;
    logic [31:0]   req_addr, wr_addr, wr_din, resp_data;
    logic          wr_en, flush;
    logic [3:0]    wr_be;

    always #5 clk = ~clk;

    i_mem_pipe #(
        .DATA_W(DW), .DEPTH(DP), .RD_LAT(RL), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_fault(resp_fault),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
        .flush(flush)
    );

    // Reference model: pending responses with the cycle they become visible.
    typedef struct {
        bit          fault;
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t        q[$];
    logic [31:0] smem [DP];
    bit          live = 1'b0;
    int          cyc = 0;
    int          n_run = 0;
    int          n_fail = 0;

    typedef struct {
        bit          rv;
        logic [31:0] ra;
        bit          rr;
        bit          we;
        logic [31:0] wa;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          e_rdy;
        bit          e_vld;
        bit          e_flt;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic bit is_bad(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 != 0) || (off < 0) || (off >= DP * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) / 4) % DP);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].due <= cyc);
    endfunction

    function automatic bit m_ready();
        return live && (q.size() < RL + 1) && !flush;
    endfunction

    function automatic vec_t rd(input bit rv, input logic [31:0] ra, input bit rr,
                                input bit er, input bit ev, input bit ef,
                                input logic [31:0] ed);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rr = rr;
        v.we = 1'b0; v.wa = '0; v.be = '0; v.wd = '0;
        v.e_rdy = er; v.e_vld = ev; v.e_flt = ef; v.e_dat = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit rv, input logic [31:0] ra, input bit rr,
                         input bit we, input logic [31:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input bit fl);
        req_valid = rv; req_addr = ra; resp_ready = rr;
        wr_en = we; wr_addr = wa; wr_be = be; wr_din = wd; flush = fl;
    endtask

    // Let inputs settle, then compare all outputs with the model.
    task automatic settle_check();
        bit v;
        #1;
        v = m_valid();
        chk("req_ready",  32'(req_ready),  32'(m_ready()));
        chk("resp_valid", 32'(resp_valid), 32'(v));
        chk("resp_fault", 32'(resp_fault), v ? 32'(q[0].fault) : 32'h0);
        chk("resp_data",  resp_data,       v ? q[0].data : 32'h0);
    endtask

    // Apply this cycle's accept/pop/flush/write to the model, then clock.
    task automatic advance();
        bit   acc, pop;
        ent_t e;
        acc = req_valid && m_ready();
        pop = m_valid() && resp_ready;
        if (flush) q.delete();
        else begin
            if (pop) q.delete(0);
            if (acc) begin
                e.fault = is_bad(req_addr);
                e.data  = e.fault ? 32'h0 : smem[widx(req_addr)];
                e.due   = cyc + RL;
                q.push_back(e);
            end
        end
        if (wr_en && !is_bad(wr_addr))
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) smem[widx(wr_addr)][b*8 +: 8] = wr_din[b*8 +: 8];
        if (!rst) live = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
        chk({tag, "_resp_data"},  resp_data,       32'h0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Preload word i = A000_0000 + i through the write port.
        for (int i = 0; i < DP; i++) begin
            drive(0, 0, 1, 1, 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), 0);
            step();
        end

        // Directed vectors: single fetch, faults, read-first write, credit stall.
        tbl.push_back(rd(1, 32'h08, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(0, 32'h00, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_0002));
        tbl.push_back(rd(0, 32'h00, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h06, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h04, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h40, 1, 1, 1, 1, 32'h0));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_0001));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 1, 32'h0));
        tbl.push_back(rd(0, 32'h00, 1, 1, 0, 0, 32'h0));
        begin
            vec_t w;
            w = rd(1, 32'h10, 1, 1, 0, 0, 32'h0);
            w.we = 1'b1; w.wa = 32'h10; w.be = 4'b0011; w.wd = 32'hDEAD_BEEF;
            tbl.push_back(w);
        end
        tbl.push_back(rd(1, 32'h10, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_0004));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_BEEF));
        tbl.push_back(rd(0, 32'h00, 1, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h00, 0, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h04, 0, 1, 0, 0, 32'h0));
        tbl.push_back(rd(1, 32'h08, 0, 1, 1, 0, 32'hA000_0000));
        tbl.push_back(rd(1, 32'h0C, 0, 0, 1, 0, 32'hA000_0000));
        tbl.push_back(rd(1, 32'h0C, 1, 0, 1, 0, 32'hA000_0000));
        tbl.push_back(rd(1, 32'h0C, 1, 1, 1, 0, 32'hA000_0001));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_0002));
        tbl.push_back(rd(0, 32'h00, 1, 1, 1, 0, 32'hA000_0003));
        tbl.push_back(rd(0, 32'h00, 1, 1, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].ra, tbl[i].rr, tbl[i].we, tbl[i].wa,
                  tbl[i].be, tbl[i].wd, 0);
            settle_check();
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(resp_valid), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_fault", i), 32'(resp_fault), 32'(tbl[i].e_flt));
            chk($sformatf("tbl%0d_data", i),  resp_data,       tbl[i].e_dat);
            advance();
        end

        // Back-to-back fetches over the whole array.
        for (int i = 0; i < DP; i++) begin
            drive(1, 32'(i * 4), 1, 0, 0, 0, 0, 0);
            #1;
            chk("b2b_ready", 32'(req_ready), 32'h1);
            #0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            step();
        end

        // Flush with responses both buffered and in flight.
        drive(1, 32'h00, 0, 0, 0, 0, 0, 0); step();
        drive(1, 32'h04, 0, 0, 0, 0, 0, 0); step();
        drive(1, 32'h08, 0, 0, 0, 0, 0, 0); step();
        drive(1, 32'h14, 1, 0, 0, 0, 0, 1);
        settle_check();
        chk("flush_ready", 32'(req_ready), 32'h0);
        advance();
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        settle_check();
        chk("flush_valid", 32'(resp_valid), 32'h0);
        advance();
        for (int i = 0; i < 4; i++) step();
        drive(1, 32'h14, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0, 0, 0);      step();
        settle_check();
        chk("post_flush_valid", 32'(resp_valid), 32'h1);
        chk("post_flush_data",  resp_data,       32'hA000_0005);
        advance();
        step();

        // Reset pulsed mid-stream drops everything asynchronously.
        drive(1, 32'h00, 0, 0, 0, 0, 0, 0); step();
        drive(1, 32'h04, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle_check();
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        q.delete();
        live = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        drive(0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(1, 32'h14, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0, 0, 0);      step();
        settle_check();
        chk("post_rst_data", resp_data, 32'hA000_0005);
        advance();
        step();

        // Randomized traffic with stalls, faults, writes and occasional flush.
        for (int i = 0; i < 600; i++) begin
            int          r, w;
            logic [31:0] a, wa;
            r = $urandom_range(0, 20);
            a = (r < 17) ? 32'(r * 4) : (r == 17) ? 32'h3E :
                (r == 18) ? 32'hFFFF_FFF0 : 32'h1;
            w = $urandom_range(0, 18);
            wa = (w < 16) ? 32'(w * 4) : (w == 16) ? 32'h40 : 32'h2;
            drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 2, wa, 4'($urandom), $urandom,
                  $urandom_range(0, 29) == 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
